pipe_mips32: RTL and testbench
==============================

Name: pipe_mips32

Overview:
- Five-stage in-order pipelined processor (IF, ID, EX, MEM, WB) for a 32-bit MIPS-like integer subset.
- A single 1024-word memory holds both instructions and data. The register file has 32 registers of 32 bits.
- Runs from PC 0 after reset until a HLT instruction retires, then freezes.
- Top-level compute block. Memory and registers are loaded or inspected hierarchically by benches and loaders through the internal arrays Mem and Reg and the state registers PC, HALTED and TAKEN_BRANCH.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the unified memory; addresses use the low log2(MEM_WORDS) bits and wrap.

Ports:
- clk  input  1  single clock; everything updates on its rising edge. One clock; reset is synchronous and active-high.
- rst  input  1  synchronous, active-high reset.
- halted  output  1  mirrors HALTED.

Behaviour:
- Encoding:
  - Fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0] (sign-extended).
  - RR ALU ops, rd = rs OP rt: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100 (signed, result 1 or 0), MUL 000101 (low 32 bits of product).
  - RM ALU ops, rt = rs OP imm: ADDI 001010, SUBI 001011, SLTI 001100.
  - LW 001000: rt = Mem[rs+imm].
  - SW 001001: Mem[rs+imm] = rt.
  - BNEQZ 001101: taken if rs != 0.
  - BEQZ 001110: taken if rs == 0.
  - Branch target = (branch PC + 1) + imm. PC is a word address.
  - HLT 111111. Any other opcode executes as a NOP.
- Register file:
  - R0 always reads 0; writes to R0 are discarded.
  - Write-through: a WB write is visible to the instruction in ID in the same cycle.
- Hazards:
  - ALU results are forwarded from EX/MEM to EX.
  - ALU and load results are forwarded from MEM/WB to EX.
  - No stalls. A consumer placed immediately after a LW gets a stale value; software guarantees at least one instruction between a LW and its consumer.
  - Forwarding never applies to R0. EX/MEM takes priority over MEM/WB.
- Branches:
  - The condition is evaluated in EX using forwarded operands.
  - If taken: PC is loaded with the target at the end of that cycle, and the IF/ID and ID/EX contents are flushed to bubbles. This is a two-cycle penalty with no delay slot.
  - TAKEN_BRANCH is high for exactly the one cycle after the redirect.
  - A not-taken branch has no effect.
- Halt:
  - When HLT is in ID, PC stops advancing and IF feeds bubbles.
  - When HLT reaches WB, HALTED is set to 1 and stays set until reset.
  - While HALTED: no Reg or Mem writes, and PC is frozen.
  - A HLT that is flushed by a taken branch has no effect.
- Memory:
  - Fetch and data accesses to the array are combinational reads.
  - SW writes at the rising edge ending its MEM cycle.
  - A load to the same address in a later cycle sees the new value.
- Latency: an instruction fetched in cycle t writes back at the edge ending cycle t+4.
- Reset (rst=1 at an edge):
  - PC=0, HALTED=0, TAKEN_BRANCH=0, all pipeline registers become bubbles.
  - Reg and Mem are not altered.
  - Applied mid-program: in-flight instructions are abandoned and no write occurs at that edge.

Decomposition:
- Package mips32_pkg:
  - opcode localparams;
  - instruction-class enum (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP);
  - a bubble/NOP instruction constant.
- Sub-module mips32_alu: combinational; takes an opcode and two 32-bit operands and returns the result. ADD, SUB, AND, OR, signed SLT and MUL share it with the immediate forms.

Test Plan:
- Factorial:
  - Program: Reg[k]=k; Mem[200]=7; ADDI R10,R0,200; ADDI R2,R0,1; OR R20,R20,R20; LW R3,0(R10); OR R20,R20,R20; loop: MUL R2,R2,R3; SUBI R3,R3,1; OR R20,R20,R20; BNEQZ R3,loop (imm -4); SW R2,-2(R10); HLT.
  - Required: halted=1 within 120 cycles, Mem[198]=5040, Mem[200]=7, R2=5040, R3=0.
- Forwarding:
  - Program: ADDI R1,R0,10; ADD R2,R1,R1; ADD R3,R2,R1; HLT.
  - Required: R2=20, R3=30 with no intervening instructions.
- Branch flush:
  - Program: BEQZ R0,+2; ADDI R5,R0,1; ADDI R6,R0,1; ADDI R7,R0,9; HLT.
  - Required: R5 and R6 unchanged, R7=9, TAKEN_BRANCH high for exactly one cycle.
- Signed SLT and R0:
  - Program: ADDI R1,R0,-1; SLTI R2,R1,0; ADDI R0,R0,5; HLT.
  - Required: R2=1, R0 reads 0.
- Halt freeze:
  - Program: HLT then SW R1,0(R0) with R1=77 and Mem[0] holding the HLT word.
  - Required: Mem[0] unchanged and PC constant for 20 cycles.
- Mid-run reset:
  - Stimulus: assert rst during the factorial loop, then release.
  - Required: PC=0, HALTED=0, and the program reruns to Mem[198]=5040, with Mem[200] reloaded to 7 before release.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared opcodes, instruction classes and pipeline bundles
// for the five-stage mips32 core.
package mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef enum logic [2:0] {
        RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP
    } iclass_e;

    // Unassigned opcode with all register fields zero
    localparam logic [31:0] BUBBLE = 32'hF800_0000;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } if_id_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        iclass_e     cls;
    } id_ex_t;

    typedef struct packed {
        iclass_e     cls;
        logic [4:0]  dst;
        logic [31:0] res;
        logic [31:0] b;
    } ex_mem_t;

    typedef struct packed {
        iclass_e     cls;
        logic [4:0]  dst;
        logic [31:0] res;
    } mem_wb_t;

    localparam if_id_t FD_BUBBLE = '{ir: BUBBLE, npc: '0};
    localparam id_ex_t DE_BUBBLE = '{
        ir: BUBBLE, npc: '0, a: '0, b: '0, cls: NOP};
    localparam ex_mem_t EM_BUBBLE = '{
        cls: NOP, dst: '0, res: '0, b: '0};
    localparam mem_wb_t MW_BUBBLE = '{
        cls: NOP, dst: '0, res: '0};

    function automatic iclass_e classify(input logic [5:0] op);
        unique case (op)
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_SLT, OP_MUL:     return RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI: return RM_ALU;
            OP_LW:                     return LOAD;
            OP_SW:                     return STORE;
            OP_BNEQZ, OP_BEQZ:         return BRANCH;
            OP_HLT:                    return HALT;
            default:                   return NOP;
        endcase
    endfunction

    // Non-writers get R0 so forwarding and writeback ignore them
    function automatic logic [4:0] dest_of(
        input iclass_e c, input logic [31:0] ir);
        unique case (c)
            RR_ALU:       return ir[15:11];
            RM_ALU, LOAD: return ir[20:16];
            default:      return 5'd0;
        endcase
    endfunction

    function automatic logic [5:0] alu_op(input logic [5:0] op);
        unique case (op)
            OP_ADDI: return OP_ADD;
            OP_SUBI: return OP_SUB;
            OP_SLTI: return OP_SLT;
            OP_SUB, OP_AND, OP_OR,
            OP_SLT, OP_MUL:  return op;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips32_if.sv
// Operand/result bundle between the EX stage and its ALU.
interface mips32_if;
    import mips32_pkg::*;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    modport master(output op, a, b, input y);
    modport slave(input op, a, b, output y);
endinterface

// File: rtl/mips32_alu.sv
// Combinational integer ALU shared by register and
// immediate instruction forms.
module mips32_alu
    import mips32_pkg::*;
(
    mips32_if.slave alu
);
    always_comb begin
        alu.y = '0;
        unique case (alu.op)
            OP_SUB: alu.y = alu.a - alu.b;
            OP_AND: alu.y = alu.a & alu.b;
            OP_OR:  alu.y = alu.a | alu.b;
            OP_SLT: alu.y = {31'd0,
                $signed(alu.a) < $signed(alu.b)};
            OP_MUL: alu.y = alu.a * alu.b;
            default: alu.y = alu.a + alu.b;
        endcase
    end
endmodule

// File: rtl/pipe_mips32.sv
// Five-stage in-order mips32 core with a unified word memory,
// EX-stage branch resolution and operand forwarding.
module pipe_mips32
    import mips32_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic clk,
    input  logic rst,
    output logic halted
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] Mem [MEM_WORDS];
    logic [31:0] Reg [32];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    if_id_t  fd_q;
    id_ex_t  de_q, de_d;
    ex_mem_t em_q, em_d;
    mem_wb_t mw_q, mw_d;

    logic [4:0]  rs_id, rt_id, rs_ex, rt_ex;
    logic [31:0] id_a, id_b, fa, fb, imm_ex, target;
    logic        wb_we, taken, hlt_seen;

    mips32_if alu_if();
    mips32_alu u_alu(.alu(alu_if));

    assign halted = HALTED;
    assign rs_id  = fd_q.ir[25:21];
    assign rt_id  = fd_q.ir[20:16];
    assign rs_ex  = de_q.ir[25:21];
    assign rt_ex  = de_q.ir[20:16];
    assign imm_ex = {{16{de_q.ir[15]}}, de_q.ir[15:0]};
    assign wb_we  = !HALTED && mw_q.dst != 5'd0;

    // Register read with write-through from WB
    always_comb begin
        id_a = '0;
        id_b = '0;
        if (rs_id != 5'd0)
            id_a = (wb_we && mw_q.dst == rs_id)
                 ? mw_q.res : Reg[rs_id];
        if (rt_id != 5'd0)
            id_b = (wb_we && mw_q.dst == rt_id)
                 ? mw_q.res : Reg[rt_id];
        de_d = '{ir: fd_q.ir, npc: fd_q.npc, a: id_a,
                 b: id_b, cls: classify(fd_q.ir[31:26])};
    end

    // EX/MEM written last so it wins over MEM/WB
    always_comb begin
        fa = de_q.a;
        fb = de_q.b;
        if (mw_q.dst != 5'd0 && mw_q.dst == rs_ex)
            fa = mw_q.res;
        if (mw_q.dst != 5'd0 && mw_q.dst == rt_ex)
            fb = mw_q.res;
        if (em_q.dst != 5'd0 && em_q.cls != LOAD) begin
            if (em_q.dst == rs_ex) fa = em_q.res;
            if (em_q.dst == rt_ex) fb = em_q.res;
        end
    end

    assign alu_if.op = alu_op(de_q.ir[31:26]);
    assign alu_if.a  = fa;
    assign alu_if.b  = (de_q.cls == RR_ALU) ? fb : imm_ex;

    assign taken  = de_q.cls == BRANCH &&
        ((de_q.ir[31:26] == OP_BEQZ) == (fa == 32'd0));
    assign target = de_q.npc + imm_ex;

    assign em_d = '{cls: de_q.cls,
                    dst: dest_of(de_q.cls, de_q.ir),
                    res: alu_if.y, b: fb};
    assign mw_d = '{cls: em_q.cls, dst: em_q.dst,
                    res: (em_q.cls == LOAD)
                       ? Mem[em_q.res[AW-1:0]] : em_q.res};

    assign hlt_seen = classify(fd_q.ir[31:26]) == HALT
                   || de_q.cls == HALT || em_q.cls == HALT
                   || mw_q.cls == HALT;

    always_ff @(posedge clk) begin
        if (rst) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            fd_q         <= FD_BUBBLE;
            de_q         <= DE_BUBBLE;
            em_q         <= EM_BUBBLE;
            mw_q         <= MW_BUBBLE;
        end else if (!HALTED) begin
            HALTED       <= mw_q.cls == HALT;
            TAKEN_BRANCH <= taken;
            em_q         <= em_d;
            mw_q         <= mw_d;
            if (taken) begin
                PC   <= target;
                fd_q <= FD_BUBBLE;
                de_q <= DE_BUBBLE;
            end else begin
                de_q <= de_d;
                if (hlt_seen) begin
                    fd_q <= FD_BUBBLE;
                end else begin
                    fd_q <= '{ir: Mem[PC[AW-1:0]],
                              npc: PC + 32'd1};
                    PC   <= PC + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !HALTED && em_q.cls == STORE)
            Mem[em_q.res[AW-1:0]] <= em_q.b;
    end

    always_ff @(posedge clk) begin
        if (!rst && wb_we)
            Reg[mw_q.dst] <= mw_q.res;
    end

endmodule

// File: tb/tb_pipe_mips32.sv
// Bench for pipe_mips32: ALU table, directed programs and
// random programs against an instruction-level model.
module tb_pipe_mips32;
    import mips32_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;

    pipe_mips32 #(.MEM_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .halted(halted));

    mips32_if aif();
    mips32_alu u_alu(.alu(aif));

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    logic [31:0] img_mem [1024];
    logic [31:0] img_reg [32];
    logic [31:0] mm [1024];
    logic [31:0] mr [32];
    localparam logic [31:0] HLT_W = 32'hFC00_0000;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          nop;
    } vec_t;

    function automatic logic [31:0] rr(
        logic [5:0] op, int rd, int rs, int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] ri(
        logic [5:0] op, int rt, int rs, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [5:0] pick_rr(int k);
        case (k)
            0: return OP_ADD;
            1: return OP_SUB;
            2: return OP_AND;
            3: return OP_OR;
            4: return OP_SLT;
            default: return OP_MUL;
        endcase
    endfunction

    task automatic check(input string name,
        input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h",
                name, act, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 1024; i++) img_mem[i] = '0;
        for (int i = 0; i < 32; i++) img_reg[i] = '0;
    endtask

    task automatic start();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.Mem[i] = img_mem[i];
        for (int i = 0; i < 32; i++) dut.Reg[i] = img_reg[i];
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input string name, input int maxc,
        output int brc);
        int c;
        c = 0;
        brc = 0;
        while (!halted && c < maxc) begin
            @(negedge clk);
            c++;
            if (dut.TAKEN_BRANCH) brc++;
        end
        check({name, " halted"}, 32'(halted), 32'd1);
    endtask

    // Sequential ISA interpreter; no notion of pipelining
    task automatic model_run();
        logic [31:0] pc, ir, a, b, imm, v, ea;
        logic [5:0] op;
        int rs, rt, rd, dst;
        for (int i = 0; i < 1024; i++) mm[i] = img_mem[i];
        for (int i = 0; i < 32; i++) mr[i] = img_reg[i];
        pc = 0;
        for (int s = 0; s < 5000; s++) begin
            ir  = mm[pc % 1024];
            op  = ir[31:26];
            rs  = int'(ir[25:21]);
            rt  = int'(ir[20:16]);
            rd  = int'(ir[15:11]);
            imm = {{16{ir[15]}}, ir[15:0]};
            a   = (rs == 0) ? 32'd0 : mr[rs];
            b   = (rt == 0) ? 32'd0 : mr[rt];
            ea  = a + imm;
            dst = 0;
            v   = 0;
            pc  = pc + 1;
            if (op == OP_HLT) break;
            case (op)
                OP_ADD: begin dst = rd; v = a + b; end
                OP_SUB: begin dst = rd; v = a - b; end
                OP_AND: begin dst = rd; v = a & b; end
                OP_OR:  begin dst = rd; v = a | b; end
                OP_SLT: begin dst = rd;
                    v = ($signed(a) < $signed(b)) ? 1 : 0; end
                OP_MUL: begin dst = rd; v = a * b; end
                OP_ADDI: begin dst = rt; v = a + imm; end
                OP_SUBI: begin dst = rt; v = a - imm; end
                OP_SLTI: begin dst = rt;
                    v = ($signed(a) < $signed(imm)) ? 1 : 0; end
                OP_LW: begin dst = rt; v = mm[ea % 1024]; end
                OP_SW: mm[ea % 1024] = b;
                OP_BNEQZ: if (a != 0) pc = pc + imm;
                OP_BEQZ:  if (a == 0) pc = pc + imm;
                default: ;
            endcase
            if (dst != 0) mr[dst] = v;
        end
    endtask

    task automatic load_fact();
        clear_img();
        for (int k = 0; k < 32; k++) img_reg[k] = k;
        img_mem[200] = 32'd7;
        img_mem[0]  = ri(OP_ADDI, 10, 0, 200);
        img_mem[1]  = ri(OP_ADDI, 2, 0, 1);
        img_mem[2]  = rr(OP_OR, 20, 20, 20);
        img_mem[3]  = ri(OP_LW, 3, 10, 0);
        img_mem[4]  = rr(OP_OR, 20, 20, 20);
        img_mem[5]  = rr(OP_MUL, 2, 2, 3);
        img_mem[6]  = ri(OP_SUBI, 3, 3, 1);
        img_mem[7]  = rr(OP_OR, 20, 20, 20);
        img_mem[8]  = ri(OP_BNEQZ, 0, 3, -4);
        img_mem[9]  = ri(OP_SW, 2, 10, -2);
        img_mem[10] = HLT_W;
    endtask

    initial begin
        vec_t vt [12];
        int brc, p, kind;
        logic [31:0] pc_hold;

        vt[0]  = '{OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0};
        vt[1]  = '{OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
        vt[2]  = '{OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0};
        vt[3]  = '{OP_AND, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0};
        vt[4]  = '{OP_OR, 32'hF0F0, 32'h0F0F, 32'hFFFF, 1'b0};
        vt[5]  = '{OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0};
        vt[6]  = '{OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
        vt[7]  = '{OP_SLT, 32'd3, 32'd3, 32'd0, 1'b0};
        vt[8]  = '{OP_MUL, 32'd7, 32'd6, 32'd42, 1'b0};
        vt[9]  = '{OP_MUL, 32'h1_0000, 32'h1_0000, 32'd0, 1'b0};
        vt[10] = '{OP_MUL, 32'hFFFF_FFFF, 32'd3,
                   32'hFFFF_FFFD, 1'b0};
        vt[11] = '{6'b000111, 32'd1, 32'd2, 32'hDEAD, 1'b1};

        aif.op = OP_ADD;
        aif.a  = '0;
        aif.b  = '0;

        repeat (2) @(negedge clk);
        check("reset halted", 32'(halted), 32'd0);
        check("reset PC", dut.PC, 32'd0);
        check("reset taken", 32'(dut.TAKEN_BRANCH), 32'd0);

        for (int i = 0; i < 12; i++) begin
            if (!vt[i].nop) begin
                aif.op = vt[i].op;
                aif.a  = vt[i].a;
                aif.b  = vt[i].b;
                #1;
                check($sformatf("alu vec%0d", i), aif.y, vt[i].exp);
            end
            clear_img();
            img_reg[1] = vt[i].a;
            img_reg[2] = vt[i].b;
            img_reg[3] = 32'hDEAD;
            img_mem[0] = rr(vt[i].op, 3, 1, 2);
            img_mem[1] = HLT_W;
            start();
            run($sformatf("pipe vec%0d", i), 40, brc);
            check($sformatf("pipe vec%0d R3", i),
                dut.Reg[3], vt[i].exp);
        end

        // Back-to-back dependencies through both forward paths
        clear_img();
        img_mem[0] = ri(OP_ADDI, 1, 0, 10);
        img_mem[1] = rr(OP_ADD, 2, 1, 1);
        img_mem[2] = rr(OP_ADD, 3, 2, 1);
        img_mem[3] = HLT_W;
        start();
        run("fwd", 40, brc);
        check("fwd R2", dut.Reg[2], 32'd20);
        check("fwd R3", dut.Reg[3], 32'd30);

        clear_img();
        img_reg[5] = 32'd55;
        img_reg[6] = 32'd66;
        img_mem[0] = ri(OP_BEQZ, 0, 0, 2);
        img_mem[1] = ri(OP_ADDI, 5, 0, 1);
        img_mem[2] = ri(OP_ADDI, 6, 0, 1);
        img_mem[3] = ri(OP_ADDI, 7, 0, 9);
        img_mem[4] = HLT_W;
        start();
        run("branch", 40, brc);
        check("branch R5", dut.Reg[5], 32'd55);
        check("branch R6", dut.Reg[6], 32'd66);
        check("branch R7", dut.Reg[7], 32'd9);
        check("branch taken cycles", 32'(brc), 32'd1);

        clear_img();
        img_mem[0] = ri(OP_ADDI, 1, 0, -1);
        img_mem[1] = ri(OP_SLTI, 2, 1, 0);
        img_mem[2] = ri(OP_ADDI, 0, 0, 5);
        img_mem[3] = HLT_W;
        start();
        run("slt", 40, brc);
        check("slt R1", dut.Reg[1], 32'hFFFF_FFFF);
        check("slt R2", dut.Reg[2], 32'd1);
        check("slt R0", dut.Reg[0], 32'd0);

        clear_img();
        img_reg[1] = 32'd77;
        img_mem[0] = HLT_W;
        img_mem[1] = ri(OP_SW, 1, 0, 0);
        start();
        run("freeze", 40, brc);
        pc_hold = dut.PC;
        repeat (20) @(negedge clk);
        check("freeze PC stable", dut.PC, pc_hold);
        check("freeze PC", dut.PC, 32'd1);
        check("freeze Mem0", dut.Mem[0], HLT_W);

        load_fact();
        start();
        run("fact", 120, brc);
        check("fact Mem198", dut.Mem[198], 32'd5040);
        check("fact Mem200", dut.Mem[200], 32'd7);
        check("fact R2", dut.Reg[2], 32'd5040);
        check("fact R3", dut.Reg[3], 32'd0);

        // Reset in the middle of the loop, then rerun
        load_fact();
        start();
        repeat (30) @(negedge clk);
        check("midrst running", 32'(halted), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst PC", dut.PC, 32'd0);
        check("midrst HALTED", 32'(dut.HALTED), 32'd0);
        dut.Mem[200] = 32'd7;
        dut.Mem[198] = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        run("midrst", 120, brc);
        check("midrst Mem198", dut.Mem[198], 32'd5040);

        for (int r = 0; r < 4; r++) begin
            clear_img();
            for (int k = 1; k < 8; k++) img_reg[k] = $urandom;
            img_reg[20] = $urandom;
            for (int k = 300; k < 308; k++) img_mem[k] = $urandom;
            p = 0;
            for (int k = 0; k < 20; k++) begin
                kind = $urandom_range(0, 9);
                if (kind <= 4)
                    img_mem[p++] = rr(pick_rr($urandom_range(0, 5)),
                        $urandom_range(1, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7));
                else if (kind <= 6)
                    img_mem[p++] = ri(
                        (kind == 5) ? OP_ADDI
                        : (($urandom_range(0, 1) == 1)
                           ? OP_SUBI : OP_SLTI),
                        $urandom_range(1, 7), $urandom_range(0, 7),
                        int'($urandom_range(0, 65535)));
                else if (kind == 7)
                    img_mem[p++] = ri(OP_SW, $urandom_range(1, 7), 0,
                        300 + $urandom_range(0, 7));
                else if (kind == 8) begin
                    img_mem[p++] = ri(OP_LW, $urandom_range(1, 7), 0,
                        300 + $urandom_range(0, 7));
                    img_mem[p++] = rr(OP_OR, 20, 20, 20);
                end else
                    img_mem[p++] = ri(
                        ($urandom_range(0, 1) == 1)
                        ? OP_BEQZ : OP_BNEQZ,
                        0, $urandom_range(0, 7), 1);
            end
            img_mem[p++] = HLT_W;
            img_mem[p]   = HLT_W;
            model_run();
            start();
            run($sformatf("rnd%0d", r), 400, brc);
            for (int k = 1; k < 8; k++)
                check($sformatf("rnd%0d R%0d", r, k),
                    dut.Reg[k], mr[k]);
            check($sformatf("rnd%0d R20", r), dut.Reg[20], mr[20]);
            for (int k = 300; k < 308; k++)
                check($sformatf("rnd%0d Mem%0d", r, k),
                    dut.Mem[k], mm[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors",
            nchk, nerr);
        $finish;
    end

endmodule
